// File: rtl/atconv_pkg.sv
// atconv_pkg: shared widths, memory depths and responder state encoding
package atconv_pkg;
  localparam int IMG_W = 64;
  localparam int L1_W = 32;
  localparam int DW = 13;
  localparam int AW = 12;
  localparam int L0_DEPTH = IMG_W * IMG_W;
  localparam int L1_DEPTH = L1_W * L1_W;
  localparam int L1_AW = $clog2(L1_DEPTH);
  typedef enum logic [2:0] {CLEAR, LOAD, READY, RUN, DONE, DUMP} state_t;
endpackage

// File: rtl/atconv_mem_resp_if.sv
// atconv_mem_resp_if: accelerator-side ready/busy handshake plus image and layer buses
interface atconv_mem_resp_if;
  import atconv_pkg::*;
  logic ready;
  logic busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic csel;
  modport master (input ready, idata, cdata_rd, output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel);
  modport slave (output ready, idata, cdata_rd, input busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel);
endinterface

// File: rtl/atconv_bank.sv
// atconv_bank: single-write-port memory with NR zero-latency read ports
module atconv_bank
  import atconv_pkg::*;
#(
  parameter int DEPTH = L0_DEPTH,
  parameter int NR = 1,
  localparam int BAW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [BAW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [BAW-1:0] raddr [NR],
  output logic [DW-1:0] rdata [NR]
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign rdata[i] = mem_q[raddr[i]];
  end
endmodule

// File: rtl/atconv_mem_resp.sv
// atconv_mem_resp: image ROM and layer banks serving the atrous-conv accelerator, with host load/dump
module atconv_mem_resp
  import atconv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  atconv_mem_resp_if.slave bus,
  input  logic ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic ld_done,
  input  logic restart,
  input  logic dump_req,
  input  logic dump_sel,
  input  logic dump_ready,
  output logic dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic dump_last,
  output logic done,
  output logic err_oob
);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, dump_addr_q;
  logic dump_sel_q, err_q;
  logic clr, run_wr, oob, accept;
  logic [AW-1:0] img_ra [1];
  logic [DW-1:0] img_rd [1];
  logic [AW-1:0] l0_ra [2];
  logic [DW-1:0] l0_rd [2];
  logic [L1_AW-1:0] l1_ra [2];
  logic [DW-1:0] l1_rd [2];
  assign clr = state_q == CLEAR && !reset;
  assign run_wr = state_q == RUN && bus.cwr && !reset;
  assign oob = bus.caddr_wr >= AW'(L1_DEPTH);
  assign accept = dump_valid && dump_ready;
  assign img_ra = '{bus.iaddr};
  assign l0_ra = '{bus.caddr_rd, dump_addr_q};
  assign l1_ra = '{bus.caddr_rd[L1_AW-1:0], dump_addr_q[L1_AW-1:0]};
  atconv_bank #(.DEPTH(L0_DEPTH), .NR(1)) u_img (
    .clk(clk), .we(state_q == LOAD && ld_valid && !reset), .waddr(ld_addr), .wdata(ld_data),
    .raddr(img_ra), .rdata(img_rd)
  );
  atconv_bank #(.DEPTH(L0_DEPTH), .NR(2)) u_l0 (
    .clk(clk), .we(clr || (run_wr && !bus.csel)), .waddr(clr ? cnt_q : bus.caddr_wr),
    .wdata(clr ? '0 : bus.cdata_wr), .raddr(l0_ra), .rdata(l0_rd)
  );
  // layer1 is cleared only over its own depth; out-of-range run writes are dropped
  atconv_bank #(.DEPTH(L1_DEPTH), .NR(2)) u_l1 (
    .clk(clk), .we((clr && cnt_q < AW'(L1_DEPTH)) || (run_wr && bus.csel && !oob)),
    .waddr(clr ? cnt_q[L1_AW-1:0] : bus.caddr_wr[L1_AW-1:0]),
    .wdata(clr ? '0 : bus.cdata_wr), .raddr(l1_ra), .rdata(l1_rd)
  );
  always_ff @(posedge clk) state_q <= reset ? CLEAR : state_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dump_addr_q <= '0;
      dump_sel_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= clr ? cnt_q + 1'b1 : '0;
      if (state_q == DONE && dump_req) begin
        dump_addr_q <= '0;
        dump_sel_q <= dump_sel;
      end else if (accept) dump_addr_q <= dump_addr_q + 1'b1;
      if (run_wr && bus.csel && oob) err_q <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: state_d = &cnt_q ? LOAD : CLEAR;
      LOAD: state_d = ld_done ? READY : LOAD;
      READY: state_d = bus.busy ? RUN : READY;
      RUN: state_d = bus.busy ? RUN : DONE;
      DONE: state_d = dump_req ? DUMP : restart ? CLEAR : DONE;
      DUMP: state_d = accept && dump_last ? DONE : DUMP;
      default: state_d = CLEAR;
    endcase
  end
  always_comb begin
    bus.ready = state_q == READY;
    done = state_q == DONE;
    dump_valid = state_q == DUMP;
    dump_addr = dump_addr_q;
    dump_last = dump_valid && dump_addr_q == (dump_sel_q ? AW'(L1_DEPTH - 1) : AW'(L0_DEPTH - 1));
    dump_data = dump_sel_q ? l1_rd[1] : l0_rd[1];
    err_oob = err_q;
    bus.idata = img_rd[0];
    bus.cdata_rd = !bus.crd ? '0 : bus.csel ? l1_rd[0] : l0_rd[0];
  end
endmodule
